// File: rtl/cordic_pkg.sv
// Shared constants and helpers for the CORDIC vectoring pipeline:
// binary-angle constants, arctangent table and the 1/K shift-add coefficient.
package cordic_pkg;

    // Binary angles with full scale 2^32 = 2*pi.
    localparam logic [31:0] ANG_PI2 = 32'h4000_0000;
    localparam logic [31:0] ANG_PI  = 32'h8000_0000;

    // 1/K ~= 39797 / 2^16 = 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13 - 2^-15 - 2^-16.
    localparam int KINV_TERMS = 32'sd7;
    localparam int KINV_FRAC  = 32'sd16;

    function automatic int kinv_shift(input int k);
        case (k)
            32'sd0:  return 32'sd1;
            32'sd1:  return 32'sd3;
            32'sd2:  return 32'sd6;
            32'sd3:  return 32'sd9;
            32'sd4:  return 32'sd13;
            32'sd5:  return 32'sd15;
            32'sd6:  return 32'sd16;
            default: return 32'sd0;
        endcase
    endfunction

    function automatic logic kinv_neg(input int k);
        case (k)
            32'sd0:  return 1'b0;
            32'sd1:  return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // round(atan(2^-i) * 2^32 / (2*pi))
    function automatic logic [31:0] atan32(input int i);
        case (i)
            32'sd0:  return 32'h2000_0000;
            32'sd1:  return 32'h12E4_051E;
            32'sd2:  return 32'h09FB_385B;
            32'sd3:  return 32'h0511_11D4;
            32'sd4:  return 32'h028B_0D43;
            32'sd5:  return 32'h0145_D7E1;
            32'sd6:  return 32'h00A2_F61E;
            32'sd7:  return 32'h0051_7C55;
            32'sd8:  return 32'h0028_BE53;
            32'sd9:  return 32'h0014_5F2F;
            32'sd10: return 32'h000A_2F98;
            32'sd11: return 32'h0005_17CC;
            32'sd12: return 32'h0002_8BE6;
            32'sd13: return 32'h0001_45F3;
            32'sd14: return 32'h0000_A2FA;
            32'sd15: return 32'h0000_517D;
            32'sd16: return 32'h0000_28BE;
            32'sd17: return 32'h0000_145F;
            32'sd18: return 32'h0000_0A30;
            32'sd19: return 32'h0000_0518;
            32'sd20: return 32'h0000_028C;
            32'sd21: return 32'h0000_0146;
            32'sd22: return 32'h0000_00A3;
            32'sd23: return 32'h0000_0051;
            32'sd24: return 32'h0000_0029;
            32'sd25: return 32'h0000_0014;
            32'sd26: return 32'h0000_000A;
            32'sd27: return 32'h0000_0005;
            32'sd28: return 32'h0000_0003;
            32'sd29: return 32'h0000_0001;
            32'sd30: return 32'h0000_0001;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // atan(2^-i) in a binary angle of the given width (1..31), rounded to nearest.
    function automatic logic [31:0] atan_lut(input int i, input int width);
        logic [32:0] sum_s;
        sum_s = {1'b0, atan32(i)} + (33'd1 << (32'sd31 - width));
        sum_s = sum_s >> (32'sd32 - width);
        return sum_s[31:0];
    endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One registered CORDIC vectoring micro-rotation (shift SHIFT) that drives y toward 0.
// The valid bit is reset; x/y/z and the tag load only for valid samples.
module cordic_vec_stage
    import cordic_pkg::*;
#(
    parameter int XY_W  = 28,
    parameter int Z_W   = 18,
    parameter int SHIFT = 0,
    parameter int CH_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   up_val,
    input  logic signed [XY_W-1:0] up_x,
    input  logic signed [XY_W-1:0] up_y,
    input  logic        [Z_W-1:0]  up_z,
    input  logic        [CH_W-1:0] up_ch,
    output logic                   val_r,
    output logic signed [XY_W-1:0] x_r,
    output logic signed [XY_W-1:0] y_r,
    output logic        [Z_W-1:0]  z_r,
    output logic        [CH_W-1:0] ch_r
);

    localparam logic [Z_W-1:0] ATAN_C = Z_W'(atan_lut(SHIFT, Z_W));

    logic signed [XY_W-1:0] x_sh_s;
    logic signed [XY_W-1:0] y_sh_s;
    logic signed [XY_W-1:0] x_nxt_s;
    logic signed [XY_W-1:0] y_nxt_s;
    logic        [Z_W-1:0]  z_nxt_s;

    // Rotate by -/+atan(2^-SHIFT) depending on the sign of y.
    always_comb begin
        x_sh_s = up_x >>> SHIFT;
        y_sh_s = up_y >>> SHIFT;
        if (!up_y[XY_W-1]) begin
            x_nxt_s = up_x + y_sh_s;
            y_nxt_s = up_y - x_sh_s;
            z_nxt_s = up_z + ATAN_C;
        end else begin
            x_nxt_s = up_x - y_sh_s;
            y_nxt_s = up_y + x_sh_s;
            z_nxt_s = up_z - ATAN_C;
        end
    end

    // Stage valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_r <= 1'b0;
        end else begin
            val_r <= up_val;
        end
    end

    // Data and tag registers, qualified by valid.
    always_ff @(posedge clk) begin
        if (up_val) begin
            x_r  <= x_nxt_s;
            y_r  <= y_nxt_s;
            z_r  <= z_nxt_s;
            ch_r <= up_ch;
        end
    end

endmodule

// File: rtl/cordic_angle_pipe.sv
// Fully pipelined CORDIC vectoring engine: atan2(imag_i, real_i) as a binary angle,
// latency ITER+2. Define CORDIC_MAG_EN to add the gain-compensated mag_o output.
module cordic_angle_pipe
    import cordic_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ANGLE_W = 16,
    parameter int ITER    = 14,
    parameter int CH_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               val_i,
    input  logic [DATA_W-1:0]  real_i,
    input  logic [DATA_W-1:0]  imag_i,
    input  logic [CH_W-1:0]    ch_i,
    output logic [ANGLE_W-1:0] angle_o,
    output logic [CH_W-1:0]    ch_o,
    output logic               val_o
`ifdef CORDIC_MAG_EN
    ,
    output logic [DATA_W:0]    mag_o
`endif
);

    // Fraction bits below the integer sample keep truncation error well under 1 LSB of angle.
    localparam int FRAC_W = ANGLE_W + 32'sd2;
    localparam int XY_W   = DATA_W + 32'sd2 + FRAC_W;
    localparam int Z_W    = ANGLE_W + 32'sd2;
    localparam logic [Z_W-1:0] Z_PI2 = Z_W'(ANG_PI2 >> (32'sd32 - Z_W));
    localparam logic [Z_W-1:0] Z_RND = Z_W'(32'd2);

    logic signed [XY_W-1:0] re_ext_s;
    logic signed [XY_W-1:0] im_ext_s;
    logic signed [XY_W-1:0] x0_s;
    logic signed [XY_W-1:0] y0_s;
    logic        [Z_W-1:0]  z0_s;

    logic                   pre_val_r;
    logic signed [XY_W-1:0] pre_x_r;
    logic signed [XY_W-1:0] pre_y_r;
    logic        [Z_W-1:0]  pre_z_r;
    logic        [CH_W-1:0] pre_ch_r;

    logic                   val_pipe_s [ITER+1];
    logic signed [XY_W-1:0] x_pipe_s   [ITER+1];
    logic signed [XY_W-1:0] y_pipe_s   [ITER+1];
    logic        [Z_W-1:0]  z_pipe_s   [ITER+1];
    logic        [CH_W-1:0] ch_pipe_s  [ITER+1];

    logic [ANGLE_W-1:0] angle_nxt_s;

    // Quadrant pre-rotation into the right half-plane; guard bits absorb -(-2^(DATA_W-1)).
    always_comb begin
        re_ext_s = {{2{real_i[DATA_W-1]}}, real_i, {FRAC_W{1'b0}}};
        im_ext_s = {{2{imag_i[DATA_W-1]}}, imag_i, {FRAC_W{1'b0}}};
        if (!real_i[DATA_W-1]) begin
            x0_s = re_ext_s;
            y0_s = im_ext_s;
            z0_s = {Z_W{1'b0}};
        end else if (!imag_i[DATA_W-1]) begin
            x0_s = im_ext_s;
            y0_s = -re_ext_s;
            z0_s = Z_PI2;
        end else begin
            x0_s = -im_ext_s;
            y0_s = re_ext_s;
            z0_s = -Z_PI2;
        end
    end

    // Pre-rotation stage valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_val_r <= 1'b0;
        end else begin
            pre_val_r <= val_i;
        end
    end

    // Pre-rotation data and tag registers.
    always_ff @(posedge clk) begin
        if (val_i) begin
            pre_x_r  <= x0_s;
            pre_y_r  <= y0_s;
            pre_z_r  <= z0_s;
            pre_ch_r <= ch_i;
        end
    end

    assign val_pipe_s[0] = pre_val_r;
    assign x_pipe_s[0]   = pre_x_r;
    assign y_pipe_s[0]   = pre_y_r;
    assign z_pipe_s[0]   = pre_z_r;
    assign ch_pipe_s[0]  = pre_ch_r;

    for (genvar i = 0; i < ITER; i++) begin : g_stage
        cordic_vec_stage #(
            .XY_W  (XY_W),
            .Z_W   (Z_W),
            .SHIFT (i),
            .CH_W  (CH_W)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .up_val (val_pipe_s[i]),
            .up_x   (x_pipe_s[i]),
            .up_y   (y_pipe_s[i]),
            .up_z   (z_pipe_s[i]),
            .up_ch  (ch_pipe_s[i]),
            .val_r  (val_pipe_s[i+1]),
            .x_r    (x_pipe_s[i+1]),
            .y_r    (y_pipe_s[i+1]),
            .z_r    (z_pipe_s[i+1]),
            .ch_r   (ch_pipe_s[i+1])
        );
    end

    // x stays at zero only for a (0,0) input; that case is forced to angle 0.
    always_comb begin
        if (~|x_pipe_s[ITER] && ~|y_pipe_s[ITER]) begin
            angle_nxt_s = {ANGLE_W{1'b0}};
        end else begin
            angle_nxt_s = ANGLE_W'((z_pipe_s[ITER] + Z_RND) >> 2);
        end
    end

`ifdef CORDIC_MAG_EN
    localparam int PROD_W = XY_W + KINV_FRAC + 32'sd1;
    localparam int MAG_W  = DATA_W + 32'sd1;

    logic [PROD_W-1:0] x_ext_s;
    logic [PROD_W-1:0] mag_acc_s;
    logic [MAG_W-1:0]  mag_nxt_s;

    // Gain compensation: final x (always >= 0) times 1/K via shift-add, truncated.
    always_comb begin
        x_ext_s   = {{(PROD_W-XY_W){1'b0}}, x_pipe_s[ITER]};
        mag_acc_s = {PROD_W{1'b0}};
        for (int k = 0; k < KINV_TERMS; k++) begin
            if (kinv_neg(k)) begin
                mag_acc_s = mag_acc_s - (x_ext_s << (KINV_FRAC - kinv_shift(k)));
            end else begin
                mag_acc_s = mag_acc_s + (x_ext_s << (KINV_FRAC - kinv_shift(k)));
            end
        end
        mag_nxt_s = MAG_W'(mag_acc_s >> (KINV_FRAC + FRAC_W));
    end
`endif

    // Output register: reset to zero, otherwise holds until the next valid sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_o   <= 1'b0;
            angle_o <= {ANGLE_W{1'b0}};
            ch_o    <= {CH_W{1'b0}};
`ifdef CORDIC_MAG_EN
            mag_o   <= {(DATA_W+1){1'b0}};
`endif
        end else begin
            val_o <= val_pipe_s[ITER];
            if (val_pipe_s[ITER]) begin
                angle_o <= angle_nxt_s;
                ch_o    <= ch_pipe_s[ITER];
`ifdef CORDIC_MAG_EN
                mag_o   <= mag_nxt_s;
`endif
            end
        end
    end

endmodule

// File: tb/tb_cordic_angle_pipe.sv
// Scoreboard bench for cordic_angle_pipe: expectations from an atan2 model are queued
// at drive time and compared when val_o is due; mag_o is checked with CORDIC_MAG_EN.
module tb_cordic_angle_pipe;

    localparam int DATA_W  = 8;
    localparam int ANGLE_W = 16;
    localparam int ITER    = 14;
    localparam int CH_W    = 2;
    localparam int LAT     = ITER + 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               val_i;
    logic [DATA_W-1:0]  real_i;
    logic [DATA_W-1:0]  imag_i;
    logic [CH_W-1:0]    ch_i;
    logic [ANGLE_W-1:0] angle_o;
    logic [CH_W-1:0]    ch_o;
    logic               val_o;
`ifdef CORDIC_MAG_EN
    logic [DATA_W:0]    mag_o;
`endif

    cordic_angle_pipe #(
        .DATA_W  (DATA_W),
        .ANGLE_W (ANGLE_W),
        .ITER    (ITER),
        .CH_W    (CH_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .val_i   (val_i),
        .real_i  (real_i),
        .imag_i  (imag_i),
        .ch_i    (ch_i),
        .angle_o (angle_o),
        .ch_o    (ch_o),
        .val_o   (val_o)
`ifdef CORDIC_MAG_EN
        ,
        .mag_o   (mag_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 due;
        logic [CH_W-1:0]    ch;
        logic [ANGLE_W-1:0] ang;
        int                 tol;
        int                 mag;
    } exp_t;

    exp_t            sb_q[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    int              cyc      = 0;
    logic [CH_W-1:0] last_ch  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol = 0);
        logic [15:0] d;
        int          sd;
        bit          ok;
        n_checks++;
        if (tol == 0) begin
            ok = (obs === exp);
        end else begin
            d  = obs[15:0] - exp[15:0];
            sd = int'($signed(d));
            ok = (^obs !== 1'bx) && (sd <= tol) && (sd >= -tol);
        end
        if (!ok) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h tol=%0d", tag, cyc, obs, exp, tol);
        end
    endtask

    function automatic logic [ANGLE_W-1:0] model_ang(input int re, input int im);
        real a;
        int  e;
        if (re == 0 && im == 0) return '0;
        a = $atan2(real'(im), real'(re));
        e = $rtoi($floor(a * 65536.0 / (2.0 * 3.14159265358979) + 0.5));
        return ANGLE_W'(e);
    endfunction

    // One clock: check what is due now, then drive the next input (sampled next edge).
    task automatic step(input logic v, input int re, input int im, input logic [CH_W-1:0] ch, input logic r);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            check("val_o", 32'(val_o), 32'd1);
            check("ch_o", 32'(ch_o), 32'(e.ch));
            check("angle_o", 32'(angle_o), 32'(e.ang), e.tol);
`ifdef CORDIC_MAG_EN
            check("mag_o", 32'(mag_o), 32'(e.mag), (e.mag == 0) ? 0 : 1);
`endif
            last_ch = e.ch;
        end else begin
            check("val_o idle", 32'(val_o), 32'd0);
            check("ch_o hold", 32'(ch_o), 32'(last_ch));
        end
        rst    = r;
        val_i  = v;
        real_i = DATA_W'(re);
        imag_i = DATA_W'(im);
        ch_i   = ch;
        if (r) begin
            sb_q.delete();
            last_ch = '0;
        end else if (v) begin
            e.due = cyc + LAT;
            e.ch  = ch;
            e.ang = model_ang(re, im);
            e.tol = (re == 0 && im == 0) ? 0 : 4;
            e.mag = $rtoi($floor($sqrt(real'(re * re + im * im))));
            sb_q.push_back(e);
        end
    endtask

    int d_re [12] = '{100, 0,    0, -128, -50,  127, 0, -128, 127, 1, 0, -1};
    int d_im [12] = '{0,   100, -100, 0,  -50, -128, 0, -128, 127, 0, 1,  0};

    initial begin
        int accepted;
        logic v;
        rst    = 1'b1;
        val_i  = 1'b0;
        real_i = '0;
        imag_i = '0;
        ch_i   = '0;

        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 2'd0, 1'b1);
        check("angle_o reset", 32'(angle_o), 32'd0);
        step(1'b0, 0, 0, 2'd0, 1'b0);

        // directed corner cases, back to back
        for (int i = 0; i < 12; i++) step(1'b1, d_re[i], d_im[i], CH_W'(i), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 0, 0, 2'd0, 1'b0);

        // random stream with gaps
        accepted = 0;
        for (int it = 0; it < 1000 && accepted < 64; it++) begin
            v = ($urandom_range(0, 99) < 60);
            step(v, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                 CH_W'($urandom_range(0, 3)), 1'b0);
            if (v) accepted++;
        end
        for (int i = 0; i < 20; i++) step(1'b0, 0, 0, 2'd0, 1'b0);

        // reset with 10 samples in flight; the sample offered with rst is discarded
        for (int i = 0; i < 10; i++) step(1'b1, 10 * i - 40, 33 - 7 * i, CH_W'(i), 1'b0);
        step(1'b1, 64, 64, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 2'd0, 1'b0);
        step(1'b1, 7, -3, 2'd3, 1'b0);
        for (int i = 0; i < 24; i++) step(1'b0, 0, 0, 2'd0, 1'b0);

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end

endmodule
